// File: rtl/rv32_isa_pkg.sv
// rv32_isa_pkg: RV32I format codes, encoder error codes and base opcodes
// shared by the instruction encoder and decoder.
package rv32_isa_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_RANGE   = 2'd2,
        ERR_ALIGN   = 2'd3
    } err_e;

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // True when v is the sign-extension of its low `bits` bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] t;
        t = $signed(v) >>> (bits - 1);
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/isa_encoder_if.sv
// isa_encoder_if: request bus, memory write port and error status of the
// instruction encoder.
interface isa_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              iValid;
    logic              oReady;
    logic [2:0]        iFmt;
    logic [6:0]        iOpCode;
    logic [4:0]        iRD;
    logic [4:0]        iRS1;
    logic [4:0]        iRS2;
    logic [2:0]        iFunc3;
    logic [6:0]        iFunc7;
    logic [31:0]       iImm;
    logic              iFlush;
    logic              iClrErr;
    logic              oWrValid;
    logic              iWrReady;
    logic [ADDR_W-1:0] oWrAddr;
    logic [31:0]       oWrData;
    logic              oWrap;
    logic              oErr;
    logic [1:0]        oErrCode;

    modport master (
        output iValid, iFmt, iOpCode, iRD, iRS1, iRS2, iFunc3, iFunc7, iImm,
               iFlush, iClrErr, iWrReady,
        input  oReady, oWrValid, oWrAddr, oWrData, oWrap, oErr, oErrCode
    );

    modport slave (
        input  iValid, iFmt, iOpCode, iRD, iRS1, iRS2, iFunc3, iFunc7, iImm,
               iFlush, iClrErr, iWrReady,
        output oReady, oWrValid, oWrAddr, oWrData, oWrap, oErr, oErrCode
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; clr empties it and
// overrides any same-cycle push or pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             do_push, do_pop;

    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata   = mem[rp[AW-1:0]];
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= do_push ? wp + 1'b1 : wp;
            rp <= do_pop ? rp + 1'b1 : rp;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/isa_encoder.sv
// isa_encoder: packs RV32I instruction fields into 32-bit words, rejects bad
// formats/immediates, and queues good words for sequential memory writes.
module isa_encoder
    import rv32_isa_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input logic          iClk,
    input logic          iRst_n,
    isa_encoder_if.slave bus
);
    logic [31:0]       imm, word, head;
    err_e              bad;
    logic              live, rdy, full, empty, acc, push, pop, wrap, err;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] addr;

    assign imm = bus.iImm;

    // Alignment is checked ahead of range so a misaligned offset reports as such.
    always_comb begin
        word = '0;
        bad  = ERR_NONE;
        case (bus.iFmt)
            FMT_R: word = {bus.iFunc7, bus.iRS2, bus.iRS1, bus.iFunc3, bus.iRD, bus.iOpCode};
            FMT_I: begin
                word = {imm[11:0], bus.iRS1, bus.iFunc3, bus.iRD, bus.iOpCode};
                bad  = fits_signed(imm, 12) ? ERR_NONE : ERR_RANGE;
            end
            FMT_S: begin
                word = {imm[11:5], bus.iRS2, bus.iRS1, bus.iFunc3, imm[4:0], bus.iOpCode};
                bad  = fits_signed(imm, 12) ? ERR_NONE : ERR_RANGE;
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], bus.iRS2, bus.iRS1, bus.iFunc3,
                        imm[4:1], imm[11], bus.iOpCode};
                bad  = imm[0] ? ERR_ALIGN : fits_signed(imm, 13) ? ERR_NONE : ERR_RANGE;
            end
            FMT_U: begin
                word = {imm[31:12], bus.iRD, bus.iOpCode};
                bad  = (imm[11:0] != '0) ? ERR_ALIGN : ERR_NONE;
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.iRD, bus.iOpCode};
                bad  = imm[0] ? ERR_ALIGN : fits_signed(imm, 21) ? ERR_NONE : ERR_RANGE;
            end
            default: bad = ERR_ILLEGAL;
        endcase
    end

    // Ready comes only from registered state, so a full queue never accepts.
    assign rdy  = live && !full;
    assign acc  = bus.iValid && rdy;
    assign push = acc && (bad == ERR_NONE) && !bus.iFlush;
    assign pop  = !empty && bus.iWrReady && !bus.iFlush;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (iClk),
        .rst_n (iRst_n),
        .clr   (bus.iFlush),
        .push  (push),
        .pop   (pop),
        .wdata (word),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            live     <= 1'b0;
            addr     <= '0;
            wrap     <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            live <= 1'b1;
            wrap <= pop && (&addr);
            addr <= bus.iFlush ? '0 : pop ? addr + 1'b1 : addr;
            if (acc && bad != ERR_NONE) begin
                err      <= 1'b1;
                err_code <= (!err || bus.iClrErr) ? bad : err_code;
            end else if (bus.iClrErr) begin
                err      <= 1'b0;
                err_code <= '0;
            end
        end
    end

    assign bus.oReady   = rdy;
    assign bus.oWrValid = !empty;
    assign bus.oWrData  = empty ? '0 : head;
    assign bus.oWrAddr  = addr;
    assign bus.oWrap    = wrap;
    assign bus.oErr     = err;
    assign bus.oErrCode = err_code;

endmodule

// File: tb/tb_isa_encoder.sv
// tb_isa_encoder: directed and randomized checks of isa_encoder against a
// behavioural model (arithmetic encoding, queue of expected words).
module tb_isa_encoder;
    import rv32_isa_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        int          fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    isa_encoder_if #(.ADDR_W(10)) bus0 ();
    isa_encoder_if #(.ADDR_W(2))  bus1 ();

    isa_encoder #(.DEPTH(DEPTH), .ADDR_W(10)) u_dut0 (.iClk(clk), .iRst_n(rst_n), .bus(bus0));
    isa_encoder #(.DEPTH(DEPTH), .ADDR_W(2))  u_dut1 (.iClk(clk), .iRst_n(rst_n), .bus(bus1));

    int vectors = 0;
    int miscompares = 0;

    req_t        cur;
    logic        valid, wr_rdy, flush, clr, last_acc;
    logic [31:0] q[$];
    int          exp_addr;
    logic        exp_wrap, exp_err, exp_live;
    logic [1:0]  exp_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input int fmt, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        req_t r;
        r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.f3 = f3; r.f7 = f7; r.imm = imm;
        return r;
    endfunction

    function automatic logic [31:0] ref_encode(input req_t r);
        logic [31:0] i, w, regs;
        i = r.imm;
        regs = (32'(r.rs1) << 15) | (32'(r.f3) << 12);
        w = 32'(r.op);
        case (r.fmt)
            0: w = w | (32'(r.f7) << 25) | (32'(r.rs2) << 20) | regs | (32'(r.rd) << 7);
            1: w = w | ((i & 32'hfff) << 20) | regs | (32'(r.rd) << 7);
            2: w = w | (((i >> 5) & 32'h7f) << 25) | (32'(r.rs2) << 20) | regs | ((i & 32'h1f) << 7);
            3: w = w | (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3f) << 25) | (32'(r.rs2) << 20)
                     | regs | (((i >> 1) & 32'hf) << 8) | (((i >> 11) & 1) << 7);
            4: w = w | (i & 32'hfffff000) | (32'(r.rd) << 7);
            5: w = w | (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3ff) << 21)
                     | (((i >> 11) & 1) << 20) | (((i >> 12) & 32'hff) << 12) | (32'(r.rd) << 7);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic int ref_code(input req_t r);
        int v;
        v = $signed(r.imm);
        case (r.fmt)
            0:       return 0;
            1, 2:    return (v >= -2048 && v < 2048) ? 0 : 2;
            3:       return (v % 2 != 0) ? 3 : (v >= -4096 && v < 4096) ? 0 : 2;
            4:       return (r.imm % 4096 != 0) ? 3 : 0;
            5:       return (v % 2 != 0) ? 3 : (v >= -(1 << 20) && v < (1 << 20)) ? 0 : 2;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        exp_addr = 0; exp_wrap = 0; exp_err = 0; exp_code = 0; exp_live = 0;
    endtask

    // Check outputs for the current state, advance the model, then clock once.
    task automatic cycle();
        int code;
        logic acc, pop;
        bus0.iValid = valid; bus0.iFmt = 3'(cur.fmt); bus0.iOpCode = cur.op;
        bus0.iRD = cur.rd; bus0.iRS1 = cur.rs1; bus0.iRS2 = cur.rs2;
        bus0.iFunc3 = cur.f3; bus0.iFunc7 = cur.f7; bus0.iImm = cur.imm;
        bus0.iFlush = flush; bus0.iClrErr = clr; bus0.iWrReady = wr_rdy;
        check("ready", bus0.oReady, exp_live && q.size() < DEPTH);
        check("wr_valid", bus0.oWrValid, q.size() > 0);
        if (q.size() > 0) check("wr_data", bus0.oWrData, q[0]);
        check("wr_addr", bus0.oWrAddr, exp_addr);
        check("wrap", bus0.oWrap, exp_wrap);
        check("err", bus0.oErr, exp_err);
        check("err_code", bus0.oErrCode, exp_code);
        acc = valid && exp_live && q.size() < DEPTH;
        pop = q.size() > 0 && wr_rdy;
        code = ref_code(cur);
        exp_wrap = 0;
        if (flush) begin
            q.delete();
            exp_addr = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                exp_wrap = exp_addr == 1023;
                exp_addr = (exp_addr + 1) % 1024;
            end
            if (acc && code == 0) q.push_back(ref_encode(cur));
        end
        if (acc && code != 0) begin
            if (!exp_err || clr) exp_code = 2'(code);
            exp_err = 1;
        end else if (clr) begin
            exp_err = 0;
            exp_code = 0;
        end
        last_acc = acc;
        exp_live = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input req_t r);
        cur = r;
        valid = 1;
        cycle();
        valid = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int k, wraps, pushed;
        logic w1;
        logic [31:0] t;
        cur = mk(0, OP_OP, 0, 0, 0, 0, 0, 0);
        valid = 0; wr_rdy = 1; flush = 0; clr = 0; last_acc = 0;
        bus0.iValid = 0; bus0.iFmt = 0; bus0.iOpCode = 0; bus0.iRD = 0; bus0.iRS1 = 0;
        bus0.iRS2 = 0; bus0.iFunc3 = 0; bus0.iFunc7 = 0; bus0.iImm = 0;
        bus0.iFlush = 0; bus0.iClrErr = 0; bus0.iWrReady = 0;
        bus1.iValid = 0; bus1.iFmt = 0; bus1.iOpCode = OP_OP; bus1.iRD = 1; bus1.iRS1 = 2;
        bus1.iRS2 = 3; bus1.iFunc3 = 0; bus1.iFunc7 = 0; bus1.iImm = 0;
        bus1.iFlush = 0; bus1.iClrErr = 0; bus1.iWrReady = 1;
        model_reset();
        rst_n = 1;
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus0.oReady, 0);
        check("rst_wr_valid", bus0.oWrValid, 0);
        check("rst_wr_addr", bus0.oWrAddr, 0);
        check("rst_wr_data", bus0.oWrData, 0);
        check("rst_wrap", bus0.oWrap, 0);
        check("rst_err", bus0.oErr, 0);
        check("rst_err_code", bus0.oErrCode, 0);
        rst_n = 1;
        cycle();
        cycle();

        send(mk(1, OP_IMM, 1, 0, 0, 0, 0, 5));
        check("i_word", bus0.oWrData, 32'h00500093);
        check("i_addr", bus0.oWrAddr, 0);
        check("i_valid", bus0.oWrValid, 1);
        send(mk(3, OP_BRANCH, 0, 0, 0, 0, 0, 32'hFFFFFFFC));
        check("b_word", bus0.oWrData, 32'hFE000EE3);
        send(mk(4, OP_LUI, 5, 0, 0, 0, 0, 32'h12345000));
        check("u_word", bus0.oWrData, 32'h123452B7);
        cycle();
        cycle();

        send(mk(5, OP_JAL, 1, 0, 0, 0, 0, 3));
        send(mk(1, OP_IMM, 1, 0, 0, 0, 0, 4096));
        check("err_set", bus0.oErr, 1);
        check("err_held", bus0.oErrCode, 3);
        check("err_nowrite", bus0.oWrValid, 0);
        clr = 1;
        cycle();
        clr = 0;
        check("err_clr", {bus0.oErr, bus0.oErrCode}, 0);
        send(mk(6, OP_OP, 0, 0, 0, 0, 0, 0));
        check("illegal_code", bus0.oErrCode, 1);
        clr = 1;
        send(mk(1, OP_IMM, 0, 0, 0, 0, 0, 32'hFFFFF000));
        clr = 0;
        check("clr_new_err", {bus0.oErr, bus0.oErrCode}, {1'b1, 2'd2});
        clr = 1;
        cycle();
        clr = 0;

        flush = 1;
        cycle();
        flush = 0;
        wr_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            cur = mk(0, OP_OP, 5'(i + 1), 5'(i), 5'(i + 2), 3'(i), 7'(i * 3), 0);
            valid = 1;
            cycle();
            if (i == 3) check("full_ready", bus0.oReady, 0);
        end
        wr_rdy = 1;
        for (int n = 0; n < 8 && !last_acc; n++) cycle();
        check("fifth_accepted", last_acc, 1);
        valid = 0;
        repeat (6) cycle();

        for (int n = 0; n < 300; n++) begin
            t = $urandom;
            cur.fmt = $urandom_range(0, 7);
            cur.op = 7'($urandom); cur.rd = 5'($urandom); cur.rs1 = 5'($urandom);
            cur.rs2 = 5'($urandom); cur.f3 = 3'($urandom); cur.f7 = 7'($urandom);
            case ($urandom_range(0, 3))
                0: cur.imm = 32'($urandom_range(0, 9999)) - 32'd5000;
                1: cur.imm = t;
                2: cur.imm = t & 32'hFFFFF000;
                default: cur.imm = {{11{t[20]}}, t[20:1], 1'b0};
            endcase
            valid = 1'($urandom);
            wr_rdy = $urandom_range(0, 3) != 0;
            clr = $urandom_range(0, 15) == 0;
            flush = !valid && $urandom_range(0, 31) == 0;
            cycle();
        end
        valid = 0; clr = 0; flush = 0; wr_rdy = 1;
        repeat (8) cycle();

        wr_rdy = 0;
        cur = mk(0, OP_OP, 7, 8, 9, 1, 0, 0);
        valid = 1;
        repeat (2) cycle();
        valid = 0;
        check("pre_rst_valid", bus0.oWrValid, 1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_valid", bus0.oWrValid, 0);
        check("mid_rst_addr", bus0.oWrAddr, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        wr_rdy = 1;
        repeat (4) cycle();

        k = 0; wraps = 0; pushed = 0; w1 = 0;
        for (int c = 0; c < 14; c++) begin
            bus1.iValid = pushed < 5;
            check("wrap1", bus1.oWrap, w1);
            wraps += int'(bus1.oWrap);
            w1 = 0;
            if (bus1.oWrValid) begin
                check("addr1", bus1.oWrAddr, k % 4);
                w1 = (k % 4) == 3;
                k++;
            end
            if (bus1.iValid && bus1.oReady) pushed++;
            cycle();
        end
        bus1.iValid = 0;
        check("writes1", k, 5);
        check("wrap_count", wraps, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
